// File: rtl/mips_data_mem_responder.sv
// mips_data_mem_responder
// -----------------------------------------------------------------------------
// Slave end of the CPU data bus: a single-ported word RAM with configurable
// read/write latency, a waitrequest stall and a one-cycle read-valid pulse.
// Byte lanes are big-endian: byteenable[0] selects data[31:24] (lowest byte
// address) through byteenable[3] selecting data[7:0].
//
// Optional feature: define DATA_MEM_ERR_EN to add the access_err output, which
// flags out-of-range or misaligned accesses.
//
// Ports:
//   clk            in   1  clock, rising edge
//   reset_n        in   1  synchronous active-low reset
//   data_read      in   1  read request
//   data_write     in   1  write request (wins over a simultaneous read)
//   data_address   in  32  byte address, bits [1:0] ignored for addressing
//   byteenable     in   4  write lane enables
//   data_writedata in  32  write data, lane-positioned
//   data_readdata  out 32  read data, holds when data_valid is low
//   data_valid     out  1  one-cycle pulse marking data_readdata valid
//   waitrequest    out  1  high while busy; requests are not accepted
//   access_err     out  1  (DATA_MEM_ERR_EN only) error pulse
// -----------------------------------------------------------------------------
module mips_data_mem_responder #(
  parameter int          ADDR_WIDTH    = 10,
  parameter logic [31:0] BASE_ADDR     = 32'h0000_1000,
  parameter int          READ_LATENCY  = 1,
  parameter int          WRITE_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        data_valid,
  output logic        waitrequest
`ifdef DATA_MEM_ERR_EN
  ,
  output logic        access_err
`endif
);

  localparam int          DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [32:0] LIMIT    = 33'(DEPTH) << 2;
  localparam logic        RD_STALL = (READ_LATENCY > 1);
  localparam logic        WR_STALL = (WRITE_LATENCY > 0);
  localparam logic [3:0]  RD_CNT   = 4'(READ_LATENCY - 1);
  localparam logic [3:0]  WR_CNT   = 4'(WRITE_LATENCY);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;

  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;

  logic        accept;
  logic        acc_read;
  logic        acc_write;
  logic        do_read;
  logic        do_write;
  logic        mem_we;

  logic [31:0] sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_wdata;
  logic [31:0] sel_off;
  logic        in_range;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH];

  assign waitrequest = (state != IDLE);

  assign accept    = (state == IDLE) && (data_read || data_write);
  assign acc_write = accept && data_write;
  assign acc_read  = accept && data_read && !data_write;

  // In IDLE the access is served straight from the bus (zero-stall cases);
  // in the wait states it is served from the fields captured at acceptance.
  assign sel_addr  = (state == IDLE) ? data_address   : cap_addr;
  assign sel_be    = (state == IDLE) ? byteenable     : cap_be;
  assign sel_wdata = (state == IDLE) ? data_writedata : cap_wdata;

  // sel_off is only meaningful when sel_addr >= BASE_ADDR, which in_range
  // checks first, so the unsigned compare needs no borrow handling.
  assign sel_off  = sel_addr - BASE_ADDR;
  assign in_range = (sel_addr >= BASE_ADDR) && ({1'b0, sel_off} < LIMIT);
  assign word_idx = sel_off[ADDR_WIDTH+1:2];
  assign rd_word  = in_range ? mem[word_idx] : 32'h0000_0000;

  // A read/write completes either at acceptance (no latency) or when the
  // counter steps from 1 to 0. Reset blocks a commit on the same edge.
  assign do_read  = (acc_read && !RD_STALL) || ((state == RD_WAIT) && (cnt == 4'd1));
  assign do_write = reset_n &&
                    ((acc_write && !WR_STALL) || ((state == WR_WAIT) && (cnt == 4'd1)));
  assign mem_we   = do_write && in_range;

  // Next-state and latency-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (acc_write && WR_STALL) begin
          state_next = WR_WAIT;
          cnt_next   = WR_CNT;
        end else if (acc_read && RD_STALL) begin
          state_next = RD_WAIT;
          cnt_next   = RD_CNT;
        end else begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
        end else begin
          state_next = state;
          cnt_next   = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // State, counter and registered read outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      data_valid    <= 1'b0;
      data_readdata <= 32'h0000_0000;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      data_valid <= do_read;
      if (do_read) begin
        data_readdata <= rd_word;
      end
    end
  end

  // Request capture at acceptance so the bus may change during the stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_addr  <= 32'h0000_0000;
      cap_be    <= 4'b0000;
      cap_wdata <= 32'h0000_0000;
    end else if (accept) begin
      cap_addr  <= data_address;
      cap_be    <= byteenable;
      cap_wdata <= data_writedata;
    end
  end

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (sel_be[0]) mem[word_idx][31:24] <= sel_wdata[31:24];
      if (sel_be[1]) mem[word_idx][23:16] <= sel_wdata[23:16];
      if (sel_be[2]) mem[word_idx][15:8]  <= sel_wdata[15:8];
      if (sel_be[3]) mem[word_idx][7:0]   <= sel_wdata[7:0];
    end
  end

`ifdef DATA_MEM_ERR_EN
  logic err_now;
  assign err_now = !in_range || (sel_addr[1:0] != 2'b00);

  // Error pulse registered on the completing edge of the access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      access_err <= 1'b0;
    end else begin
      access_err <= (do_read || do_write) && err_now;
    end
  end
`endif

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder. Three instances with different
// latencies share address/lane/data buses but have private strobes and resets.
module tb_mips_data_mem_responder;

  logic        clk;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;

  logic rst1, rd1, wr1, v1, w1;
  logic rst3, rd3, wr3, v3, w3;
  logic rst4, rd4, wr4, v4, w4;
  logic [31:0] q1, q3, q4;
`ifdef DATA_MEM_ERR_EN
  logic e1, e3, e4;
`endif

  int total = 0;
  int bad   = 0;

  mips_data_mem_responder u1 (
    .clk(clk), .reset_n(rst1), .data_read(rd1), .data_write(wr1),
    .data_address(addr), .byteenable(be), .data_writedata(wdata),
    .data_readdata(q1), .data_valid(v1), .waitrequest(w1)
`ifdef DATA_MEM_ERR_EN
    , .access_err(e1)
`endif
  );

  mips_data_mem_responder #(.READ_LATENCY(3), .WRITE_LATENCY(2)) u3 (
    .clk(clk), .reset_n(rst3), .data_read(rd3), .data_write(wr3),
    .data_address(addr), .byteenable(be), .data_writedata(wdata),
    .data_readdata(q3), .data_valid(v3), .waitrequest(w3)
`ifdef DATA_MEM_ERR_EN
    , .access_err(e3)
`endif
  );

  mips_data_mem_responder #(.READ_LATENCY(4), .WRITE_LATENCY(2)) u4 (
    .clk(clk), .reset_n(rst4), .data_read(rd4), .data_write(wr4),
    .data_address(addr), .byteenable(be), .data_writedata(wdata),
    .data_readdata(q4), .data_valid(v4), .waitrequest(w4)
`ifdef DATA_MEM_ERR_EN
    , .access_err(e4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    {rst1, rst3, rst4} = 3'b000;
    {rd1, wr1, rd3, wr3, rd4, wr4} = 6'b000000;
    addr = 32'h0; be = 4'h0; wdata = 32'h0;
    tick(); tick();
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_rdata", q1, 32'h0);
    chk("rst_wait1", {31'd0, w1}, 32'd0);
    chk("rst_wait3", {31'd0, w3}, 32'd0);
    {rst1, rst3, rst4} = 3'b111;

    // Defaults: write then read, no stall
    addr = 32'h1000; wdata = 32'hDEADBEEF; be = 4'b1111; wr1 = 1'b1;
    tick();
    chk("t1_wr_wait", {31'd0, w1}, 32'd0);
    wr1 = 1'b0; rd1 = 1'b1;
    tick();
    chk("t1_valid", {31'd0, v1}, 32'd1);
    chk("t1_rdata", q1, 32'hDEADBEEF);
    chk("t1_rd_wait", {31'd0, w1}, 32'd0);
`ifdef DATA_MEM_ERR_EN
    chk("t1_err", {31'd0, e1}, 32'd0);
`endif
    rd1 = 1'b0;
    tick();
    chk("t1_valid_drop", {31'd0, v1}, 32'd0);
    chk("t1_rdata_hold", q1, 32'hDEADBEEF);

    // Byte lanes, read-after-write back to back
    addr = 32'h1001; wdata = 32'h00AA0000; be = 4'b0010; wr1 = 1'b1;
    tick();
    wr1 = 1'b0; rd1 = 1'b1; addr = 32'h1000;
    tick();
    chk("t2_lane1", q1, 32'hDEAABEEF);
    rd1 = 1'b0; wr1 = 1'b1; wdata = 32'h00000011; be = 4'b1000;
    tick();
    wr1 = 1'b0; rd1 = 1'b1;
    tick();
    chk("t2_lane3", q1, 32'hDEAABE11);
    chk("t2_valid", {31'd0, v1}, 32'd1);
    rd1 = 1'b0;

    // Range: last word gets a marker, then out-of-range writes on both sides
    addr = 32'h1FFC; wdata = 32'hCAFEF00D; be = 4'b1111; wr1 = 1'b1;
    tick();
    addr = 32'h0FFC; wdata = 32'h12345678;
    tick();
`ifdef DATA_MEM_ERR_EN
    chk("t4_err_wlow", {31'd0, e1}, 32'd1);
`endif
    addr = 32'h2000;
    tick();
    wr1 = 1'b0; rd1 = 1'b1; addr = 32'h0FFC;
    tick();
    chk("t4_rd_low", q1, 32'h0);
    chk("t4_rd_low_v", {31'd0, v1}, 32'd1);
`ifdef DATA_MEM_ERR_EN
    chk("t4_err_rlow", {31'd0, e1}, 32'd1);
`endif
    addr = 32'h2000;
    tick();
    chk("t4_rd_high", q1, 32'h0);
    addr = 32'h1000;
    tick();
    chk("t4_word0_kept", q1, 32'hDEAABE11);
    addr = 32'h1FFC;
    tick();
    chk("t4_last_kept", q1, 32'hCAFEF00D);
`ifdef DATA_MEM_ERR_EN
    chk("t4_err_ok", {31'd0, e1}, 32'd0);
`endif
    addr = 32'h1002;
    tick();
    chk("t4_misalign_data", q1, 32'hDEAABE11);
`ifdef DATA_MEM_ERR_EN
    chk("t4_err_misalign", {31'd0, e1}, 32'd1);
`endif
    rd1 = 1'b0;

    // Collision: write wins, no read pulse
    addr = 32'h1004; wdata = 32'h55667788; be = 4'b1111; rd1 = 1'b1; wr1 = 1'b1;
    tick();
    chk("t6_coll_novalid", {31'd0, v1}, 32'd0);
    wr1 = 1'b0;
    tick();
    chk("t6_coll_data", q1, 32'h55667788);
    rd1 = 1'b0;

    // Streaming: eight writes then eight back-to-back reads
    wr1 = 1'b1; be = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h1000 + 32'(4 * i);
      wdata = 32'hA000_0000 + 32'(i);
      tick();
    end
    wr1 = 1'b0; rd1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = 32'h1000 + 32'(4 * i);
      tick();
      chk("t6_stream_v", {31'd0, v1}, 32'd1);
      chk("t6_stream_d", q1, 32'hA000_0000 + 32'(i));
    end
    rd1 = 1'b0;
    tick();
    chk("t6_stream_end", {31'd0, v1}, 32'd0);

    // Latency on u3: write stall 2, read held during stall, read latency 3
    addr = 32'h1000; wdata = 32'h13572468; be = 4'b1111; wr3 = 1'b1;
    tick();
    chk("t3_wstall_a", {31'd0, w3}, 32'd1);
    wr3 = 1'b0; rd3 = 1'b1;
    tick();
    chk("t3_wstall_b", {31'd0, w3}, 32'd1);
    tick();
    chk("t3_wdone", {31'd0, w3}, 32'd0);
    chk("t3_noearly_v", {31'd0, v3}, 32'd0);
    tick();
    chk("t3_rstall_a", {31'd0, w3}, 32'd1);
    rd3 = 1'b0;
    tick();
    chk("t3_rstall_b", {31'd0, w3}, 32'd1);
    chk("t3_rnotyet", {31'd0, v3}, 32'd0);
    tick();
    chk("t3_rvalid", {31'd0, v3}, 32'd1);
    chk("t3_rdata", q3, 32'h13572468);
    chk("t3_rwait_end", {31'd0, w3}, 32'd0);
    tick();
    chk("t3_rvalid_drop", {31'd0, v3}, 32'd0);

    // Reset mid-op on u4
    addr = 32'h1000; wdata = 32'h11112222; be = 4'b1111; wr4 = 1'b1;
    tick();
    wr4 = 1'b0;
    tick(); tick();
    chk("t5_wr_done", {31'd0, w4}, 32'd0);
    rd4 = 1'b1;
    tick();
    chk("t5_rd_stall", {31'd0, w4}, 32'd1);
    rd4 = 1'b0; rst4 = 1'b0;
    tick();
    chk("t5_rst_wait", {31'd0, w4}, 32'd0);
    chk("t5_rst_valid", {31'd0, v4}, 32'd0);
    rst4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_late_valid", {31'd0, v4}, 32'd0);
    end
    wdata = 32'h99999999; wr4 = 1'b1;
    tick();
    wr4 = 1'b0;
    tick();
    rst4 = 1'b0;
    tick();
    chk("t5_wr_rst_wait", {31'd0, w4}, 32'd0);
    rst4 = 1'b1; rd4 = 1'b1;
    tick();
    rd4 = 1'b0;
    tick(); tick(); tick();
    chk("t5_old_valid", {31'd0, v4}, 32'd1);
    chk("t5_old_data", q4, 32'h11112222);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_data_mem_responder.md
Name: mips_data_mem_responder

Overview:
Synthesizable data-memory responder for the CPU's data bus. It is the slave end of the bus on which the datapath issues word-aligned addresses, byteenables and write data. It is single-ported word RAM with configurable read and write latency, a waitrequest stall and a one-cycle read-valid pulse. Byte lanes are big-endian: byteenable[0] maps to data[31:24], the lowest byte address.

Parameters:
ADDR_WIDTH, 10, log2 of RAM depth in 32-bit words.
BASE_ADDR, 32'h0000_1000, byte address of word 0; must be 4-aligned.
READ_LATENCY, 1, cycles from request acceptance to data_valid; legal range 1..15.
WRITE_LATENCY, 0, extra stall cycles before a write commits; legal range 0..15.

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
data_read  input  1  read request
data_write  input  1  write request
data_address  input  32  byte address; bits [1:0] ignored
byteenable  input  4  write lane enables, bit0 = [31:24] … bit3 = [7:0]; ignored on reads
data_writedata  input  32  write data, lane-positioned
data_readdata  output  32  read data, full word
data_valid  output  1  one-cycle pulse, data_readdata valid
waitrequest  output  1  high = responder busy, request not accepted

Behaviour:
- Reset (reset_n low at an edge):
  - state IDLE, latency counter 0, data_valid 0, data_readdata 32'h0, waitrequest 0.
  - RAM contents are not cleared.
- Reset mid-operation discards any pending read (no data_valid) and any uncommitted write.
- waitrequest = (state != IDLE). It is combinational from the state register.
- Acceptance: a request is accepted at a rising edge where state == IDLE and data_read or data_write is high.
  - On acceptance, address, byteenable and writedata are captured.
  - If both data_read and data_write are high, the write wins and the read is dropped.
- Range check: in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4·2^ADDR_WIDTH). Word index = (addr - BASE_ADDR)[ADDR_WIDTH+1:2].
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- Read accepted at edge k:
  - READ_LATENCY = 1: stay IDLE. At edge k, data_readdata and data_valid are registered. data_valid is high between edges k and k+1.
  - READ_LATENCY > 1: go to RD_WAIT with counter = READ_LATENCY-1, decrementing each edge. At the edge where the counter reaches 0, register the data, pulse data_valid and return to IDLE.
  - data_valid is therefore first high READ_LATENCY-1 edges after edge k.
  - An out-of-range read returns 32'h0000_0000.
- Write accepted at edge k:
  - WRITE_LATENCY = 0: the enabled lanes commit at edge k, with no stall.
  - WRITE_LATENCY > 0: go to WR_WAIT with counter = WRITE_LATENCY. The write commits at the edge where the counter reaches 0, then return to IDLE. waitrequest is high for exactly WRITE_LATENCY cycles.
  - Out-of-range writes are ignored. byteenable = 4'b0000 writes nothing.
- data_valid never asserts for writes. data_readdata holds its last value when data_valid is low.
- Back-to-back: with READ_LATENCY = 1 a new request can be accepted in the same cycle data_valid is high. Sustained throughput is 1 request/cycle.
- Read-after-write to the same word returns the post-write data, including partially written lanes merged with old lanes.
- The inputs are registered at acceptance, so they may change freely after the accepting edge.

Optional Feature:
- Macro DATA_MEM_ERR_EN.
- When defined, the block adds an output port access_err (1 bit, reset 0).
  - It pulses for one cycle, coincident with data_valid for reads, or in the cycle after the commit edge for writes.
  - It pulses when the access is out of range or data_address[1:0] != 2'b00.
  - Misaligned accesses otherwise proceed using the aligned word.
- When undefined, the port is absent and errors are silent.

Test Plan:
1. Defaults. Write 32'hDEADBEEF, be=4'b1111 at 32'h1000, then read 32'h1000 → data_valid one cycle after read acceptance, data_readdata = 32'hDEADBEEF, waitrequest always 0.
2. Byte lanes. After test 1, write 32'h00AA0000 be=4'b0010 at 32'h1001, then read 32'h1000 → 32'hDEAABEEF. Write be=4'b1000 data 32'h00000011 → read gives 32'hDEAABE11.
3. Latency. READ_LATENCY=3, WRITE_LATENCY=2. A write stalls waitrequest for 2 cycles. A read raises waitrequest for 2 cycles, and data_valid rises 2 edges after acceptance. Requests held during waitrequest are accepted only once IDLE.
4. Range. Read 32'h0000_0FFC and 32'h1000+4096 → 32'h0; writes there leave RAM unchanged. With DATA_MEM_ERR_EN, access_err pulses; a read at 32'h1002 also pulses it.
5. Reset mid-op. READ_LATENCY=4: assert reset_n=0 one cycle after acceptance → no data_valid, waitrequest 0 next cycle. A pending WR_WAIT write is not committed (old data is read back).
6. Collision and streaming. data_read=data_write=1 → only the write occurs, no data_valid. Eight consecutive reads with READ_LATENCY=1 → eight consecutive data_valid pulses with the correct words.
